// File: rtl/ucode_loader.sv
// ucode_loader: assembles an 8-bit byte stream (valid/ready) into 24-bit
// microinstructions, MSB byte first. It writes them to consecutive
// control-store addresses, starting at a base address captured on start.
//
// Ports:
//   clk, rst_n       clock; synchronous active-low reset
//   start            begin a load (honoured only when idle)
//   base_addr        first write address, sampled on accepted start
//   num_words        words to load (0..2^ADDR_W), sampled on accepted start
//   byte_data/valid  incoming byte stream
//   byte_ready       loader accepts a byte this cycle
//   wr_en/addr/data  control-store write port (one strobe per word)
//   busy             load in progress (cycle after start .. final write)
//   done             one-cycle pulse when the load completes
module ucode_loader #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cur_addr;
  logic [ADDR_W:0]     r_remaining;
  logic [1:0]          r_idx;
  logic [WORD_W-1:0]   r_shift;
  logic                r_byte_ready;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [WORD_W-1:0]   r_wr_data;
  logic                r_busy;
  logic                r_done;
  logic [WORD_W-1:0]   w_next_word;

  // Word as it looks once the current byte is shifted in.
  assign w_next_word = {r_shift[WORD_W-9:0], byte_data};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cur_addr   <= '0;
      r_remaining  <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_byte_ready <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cur_addr  <= base_addr;
            r_remaining <= num_words;
            r_idx       <= '0;
            if (num_words == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state      <= S_RECV;
              r_byte_ready <= 1'b1;
              r_busy       <= 1'b1;
            end
          end
        end
        S_RECV: begin
          if (byte_valid) begin
            r_shift <= w_next_word;
            if (r_idx == 2'd2) begin
              // Output registers are loaded on entry so wr_en lines up
              // with the WRITE state without a combinational path.
              r_idx        <= '0;
              r_state      <= S_WRITE;
              r_byte_ready <= 1'b0;
              r_wr_en      <= 1'b1;
              r_wr_addr    <= r_cur_addr;
              r_wr_data    <= w_next_word;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
        end
        S_WRITE: begin
          r_cur_addr  <= r_cur_addr + 1'b1;
          r_remaining <= r_remaining - 1'b1;
          if (r_remaining == (ADDR_W+1)'(1)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state      <= S_RECV;
            r_byte_ready <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign byte_ready = r_byte_ready;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_ucode_loader.sv
module tb_ucode_loader;

  localparam int AW = 8;
  localparam int WW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_words;
  logic [7:0]    byte_data;
  logic          byte_valid;
  logic          byte_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [WW-1:0] wr_data;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  ucode_loader #(.ADDR_W(AW), .WORD_W(WW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .num_words  (num_words),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: transaction-level view of the load.
  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [23:0] data;
    bit          last;
  } wr_t;

  wr_t         wq[$];        // expected writes with their cycle
  int          dq[$];        // expected done cycles
  logic [7:0]  m_buf[$];
  logic [7:0]  m_addr;
  int          m_left;
  bit          m_active;
  int          m_busy_start;
  logic [7:0]  m_last_addr;
  logic [23:0] m_last_data;
  int          last_acc;

  // Observed activity logs for directed checks.
  logic [7:0]  la[$];
  logic [23:0] ld[$];
  int          lc[$];
  int          ldone[$];
  int          busy_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    wq.delete();
    dq.delete();
    m_buf.delete();
    m_active    = 1'b0;
    m_left      = 0;
    m_last_addr = '0;
    m_last_data = '0;
  endtask

  task automatic model_start(input logic [7:0] b, input int n);
    m_addr = b;
    m_left = n;
    m_buf.delete();
    if (n == 0) dq.push_back(cyc + 1);
    else begin
      m_active     = 1'b1;
      m_busy_start = cyc + 1;
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input int acc);
    wr_t w;
    m_buf.push_back(b);
    if (m_buf.size() == 3) begin
      m_left--;
      w.cyc  = acc + 1;
      w.addr = m_addr;
      w.data = {m_buf[0], m_buf[1], m_buf[2]};
      w.last = (m_left == 0);
      wq.push_back(w);
      if (w.last) dq.push_back(acc + 2);
      m_addr = m_addr + 8'd1;
      m_buf.delete();
    end
  endtask

  task automatic clear_logs();
    la.delete(); ld.delete(); lc.delete(); ldone.delete();
  endtask

  task automatic start_load(input logic [7:0] b, input int n);
    start     = 1'b1;
    base_addr = b;
    num_words = 9'(n);
    model_start(b, n);
    tick();
    start = 1'b0;
  endtask

  task automatic push(input logic [7:0] b, input int gap);
    int tries;
    repeat (gap) tick();
    byte_data  = b;
    byte_valid = 1'b1;
    tries = 0;
    while (!byte_ready && tries < 20) begin
      tick();
      tries++;
    end
    if (!byte_ready) begin
      chk("byte accept timeout", 32'(tries), 32'(0));
      byte_valid = 1'b0;
    end else begin
      last_acc = cyc;
      model_byte(b, cyc);
      tick();
      byte_valid = 1'b0;
    end
  endtask

  task automatic offer_extra(input logic [7:0] b, input int n);
    byte_data  = b;
    byte_valid = 1'b1;
    repeat (n) begin
      chk("extra byte_ready", 32'(byte_ready), 32'(0));
      tick();
    end
    byte_valid = 1'b0;
  endtask

  task automatic end_test(input string nm);
    repeat (4) tick();
    chk({nm, " pending writes"}, 32'(wq.size()), 32'(0));
    chk({nm, " pending done"}, 32'(dq.size()), 32'(0));
  endtask

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        bit  ew, ed, eb, er;
        wr_t w;
        ew = (wq.size() > 0) && (wq[0].cyc == cyc);
        ed = (dq.size() > 0) && (dq[0] == cyc);
        eb = m_active && (cyc >= m_busy_start);
        er = eb && !ew;
        chk("busy", 32'(busy), 32'(eb));
        chk("byte_ready", 32'(byte_ready), 32'(er));
        chk("done", 32'(done), 32'(ed));
        chk("wr_en", 32'(wr_en), 32'(ew));
        if (busy) busy_cnt++;
        if (done) ldone.push_back(cyc);
        if (wr_en) begin
          la.push_back(wr_addr);
          ld.push_back(wr_data);
          lc.push_back(cyc);
        end
        if (ed) void'(dq.pop_front());
        if (ew) begin
          w = wq.pop_front();
          m_last_addr = w.addr;
          m_last_data = w.data;
          if (w.last) m_active = 1'b0;
        end
        chk("wr_addr", 32'(wr_addr), 32'(m_last_addr));
        chk("wr_data", 32'(wr_data), 32'(m_last_data));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp_a[4];
    rst_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0;
    byte_data = '0; byte_valid = 1'b0;
    busy_cnt = 0; last_acc = 0;
    model_reset();
    repeat (3) tick();
    chk("reset ctl", 32'({byte_ready, wr_en, busy, done}), 32'(0));
    chk("reset wr_addr", 32'(wr_addr), 32'(0));
    chk("reset wr_data", 32'(wr_data), 32'(0));
    rst_n = 1'b1;
    tick();

    // Single word, then extra bytes must not be taken.
    clear_logs();
    start_load(8'h10, 1);
    push(8'hA5, 0); push(8'h5A, 0); push(8'h3C, 0);
    repeat (3) tick();
    offer_extra(8'hEE, 4);
    chk("single count", 32'(la.size()), 32'(1));
    chk("single done count", 32'(ldone.size()), 32'(1));
    if (la.size() == 1 && ldone.size() == 1) begin
      chk("single addr", 32'(la[0]), 32'h10);
      chk("single data", 32'(ld[0]), 32'hA55A3C);
      chk("single done lag", 32'(ldone[0] - lc[0]), 32'(1));
    end
    end_test("single");

    // Wrap-around across the top of the store.
    clear_logs();
    start_load(8'hFE, 4);
    for (int i = 0; i < 12; i++) push(8'(i * 17 + 3), 0);
    end_test("wrap");
    exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;
    chk("wrap count", 32'(la.size()), 32'(4));
    if (la.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("wrap addr", 32'(la[i]), 32'(exp_a[i]));
      for (int i = 1; i < 4; i++) chk("wrap spacing", 32'(lc[i] - lc[i-1]), 32'(4));
    end

    // Stalled source: valid pattern 1,0,0,1,0,1.
    clear_logs();
    start_load(8'h40, 1);
    push(8'h12, 0); push(8'h34, 2); push(8'h56, 1);
    end_test("stall");
    chk("stall count", 32'(la.size()), 32'(1));
    if (la.size() == 1) begin
      chk("stall data", 32'(ld[0]), 32'h123456);
      chk("stall latency", 32'(lc[0] - last_acc), 32'(1));
    end

    // Zero length.
    clear_logs();
    start_load(8'h33, 0);
    chk("zero done", 32'(done), 32'(1));
    chk("zero busy", 32'(busy), 32'(0));
    offer_extra(8'h77, 3);
    end_test("zero");
    chk("zero writes", 32'(la.size()), 32'(0));
    chk("zero done count", 32'(ldone.size()), 32'(1));

    // Start pulses during a load are ignored.
    clear_logs();
    start_load(8'h50, 2);
    push(8'h01, 0); push(8'h02, 0); push(8'h03, 0);
    start = 1'b1; base_addr = 8'h80; num_words = 9'd5;
    tick();
    start = 1'b0;
    push(8'h04, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    push(8'h05, 0); push(8'h06, 0);
    end_test("ignstart");
    chk("ignstart count", 32'(la.size()), 32'(2));
    if (la.size() == 2) begin
      chk("ignstart addr0", 32'(la[0]), 32'h50);
      chk("ignstart addr1", 32'(la[1]), 32'h51);
      chk("ignstart data0", 32'(ld[0]), 32'h010203);
      chk("ignstart data1", 32'(ld[1]), 32'h040506);
    end

    // Reset mid-load, then a clean load.
    clear_logs();
    start_load(8'h60, 2);
    push(8'hAA, 0); push(8'hBB, 0);
    rst_n = 1'b0;
    model_reset();
    tick();
    chk("midrst ctl", 32'({byte_ready, wr_en, busy, done}), 32'(0));
    chk("midrst wr_addr", 32'(wr_addr), 32'(0));
    chk("midrst wr_data", 32'(wr_data), 32'(0));
    rst_n = 1'b1;
    repeat (6) tick();
    chk("midrst no write", 32'(la.size()), 32'(0));
    start_load(8'h20, 1);
    push(8'h00, 0); push(8'h00, 0); push(8'h01, 0);
    end_test("midrst");
    chk("midrst count", 32'(la.size()), 32'(1));
    if (la.size() == 1) begin
      chk("midrst addr", 32'(la[0]), 32'h20);
      chk("midrst data", 32'(ld[0]), 32'h000001);
    end

    // Full store.
    clear_logs();
    busy_cnt = 0;
    start_load(8'h00, 256);
    for (int k = 0; k < 256; k++) begin
      push(8'(k), 0); push(8'(k), 0); push(8'(k), 0);
    end
    end_test("full");
    chk("full count", 32'(la.size()), 32'(256));
    if (la.size() == 256) begin
      for (int k = 0; k < 256; k++) begin
        chk("full addr", 32'(la[k]), 32'(k));
        chk("full data", 32'(ld[k]), 32'({8'(k), 8'(k), 8'(k)}));
      end
    end
    chk("full busy cycles", 32'(busy_cnt), 32'(1024));
    chk("full done count", 32'(ldone.size()), 32'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
